// File: rtl/axis_miner_loader.sv
// ---------------------------------------------------------------------------
// axis_miner_loader
//
// Upstream stage of the AXI-Stream bitcoin miner wrapper. Collects one
// block-header frame of NUMBER_OF_INPUT_WORDS words from an AXI-Stream slave,
// packs it into the flat in_fifo bus, fires a one-cycle en pulse, and then
// refuses further input until the miner signals completion with a rising
// edge on done. Frames whose tlast does not land on the final word are
// dropped and reported with a one-cycle frame_err pulse.
//
// Optional build macro:
//   LOADER_BYTE_SWAP_EN  - byte-reverse every captured word before storage
//                          (little-endian serialized header -> big-endian
//                          miner words). AXIS_TDATA_WIDTH must be a multiple
//                          of 8. Undefined: words are stored verbatim.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   asynchronous active-low reset
//   s_axis_tdata   in   stream data word
//   s_axis_tvalid  in   stream valid
//   s_axis_tlast   in   last word of frame
//   s_axis_tready  out  stream ready (low while in reset)
//   in_fifo        out  packed frame, word j at [j*W +: W]
//   en             out  one-cycle start pulse to the miner
//   done           in   miner completion level (only its 0->1 edge counts)
//   busy           out  high from frame capture until miner completion
//   frame_err      out  one-cycle pulse per dropped malformed frame
//   state_dbg      out  current FSM state (0 RECV, 1 DRAIN, 2 START, 3 WAIT)
//
// Handshake: a word transfers on a rising clk edge where s_axis_tvalid and
// s_axis_tready are both high; tready never depends on tvalid.
// ---------------------------------------------------------------------------
module axis_miner_loader #(
  parameter int NUMBER_OF_INPUT_WORDS = 20,
  parameter int AXIS_TDATA_WIDTH      = 32
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [AXIS_TDATA_WIDTH-1:0]                       s_axis_tdata,
  input  logic                                              s_axis_tvalid,
  input  logic                                              s_axis_tlast,
  output logic                                              s_axis_tready,
  output logic [NUMBER_OF_INPUT_WORDS*AXIS_TDATA_WIDTH-1:0] in_fifo,
  output logic                                              en,
  input  logic                                              done,
  output logic                                              busy,
  output logic                                              frame_err,
  output logic [1:0]                                        state_dbg
);

  localparam int N  = NUMBER_OF_INPUT_WORDS;
  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    S_RECV  = 2'd0,
    S_DRAIN = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q;
  logic          err_d;
  logic          wr_en;
  logic          rdy;
  logic          xfer;
  logic [W-1:0]  words_q [N];

  // Storage format of a captured word.
  function automatic logic [W-1:0] fmt_word(input logic [W-1:0] d);
    logic [W-1:0] r;
`ifdef LOADER_BYTE_SWAP_EN
    r = '0;
    for (int b = 0; b < W / 8; b++) begin
      r[b*8 +: 8] = d[W-8-b*8 +: 8];
    end
`else
    r = d;
`endif
    return r;
  endfunction

  // Gating with reset keeps tready low for the whole time reset is held,
  // even though the state register already reads RECV.
  assign rdy           = reset && ((state_q == S_RECV) || (state_q == S_DRAIN));
  assign s_axis_tready = rdy;
  assign xfer          = s_axis_tvalid && rdy;
  assign state_dbg     = state_q;

  // Next-state and outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    en      = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_RECV: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = s_axis_tlast ? S_START : S_DRAIN;
          end else if (s_axis_tlast) begin
            // Short frame: partial data stays in in_fifo, but no en follows.
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (xfer && s_axis_tlast) begin
          err_d   = 1'b1;
          state_d = S_RECV;
        end
      end
      S_START: begin
        en      = 1'b1;
        busy    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // A done level left over from the previous job has done_q high and
        // therefore cannot complete this one.
        if (done && !done_q) begin
          state_d = S_RECV;
        end
      end
      default: state_d = S_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RECV;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done;
      frame_err <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N; j++) begin
        words_q[j] <= '0;
      end
    end else if (wr_en) begin
      words_q[cnt_q] <= fmt_word(s_axis_tdata);
    end
  end

  always_comb begin
    in_fifo = '0;
    for (int j = 0; j < N; j++) begin
      in_fifo[j*W +: W] = words_q[j];
    end
  end

endmodule

// File: tb/tb_axis_miner_loader.sv
// ---------------------------------------------------------------------------
// tb_axis_miner_loader
//
// Directed bench for axis_miner_loader. Stimulus pushes the expected in_fifo
// image for every good frame into exp_q and a token for every expected
// frame_err into err_q; a monitor on the falling edge pops and compares each
// time the DUT pulses en or frame_err.
// ---------------------------------------------------------------------------
module tb_axis_miner_loader;

  localparam int N  = 20;
  localparam int W  = 32;
  localparam int FW = N * W;

  logic          clk;
  logic          reset;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [FW-1:0] in_fifo;
  logic          en;
  logic          done;
  logic          busy;
  logic          frame_err;
  logic [1:0]    state_dbg;

  axis_miner_loader #(
    .NUMBER_OF_INPUT_WORDS(N),
    .AXIS_TDATA_WIDTH(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .in_fifo(in_fifo),
    .en(en),
    .done(done),
    .busy(busy),
    .frame_err(frame_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [FW-1:0] exp_q [$];
  logic          err_q [$];
  logic [W-1:0]  fr [0:31];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] bswap(input logic [W-1:0] d);
`ifdef LOADER_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [FW-1:0] pack_frame();
    logic [FW-1:0] v;
    for (int j = 0; j < N; j++) v[j*W +: W] = bswap(fr[j]);
    return v;
  endfunction

  // ---------------- monitor ----------------
  logic prev_en  = 1'b0;
  logic prev_err = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL en_unexpected: en=1 with no frame expected");
        end else begin
          logic [FW-1:0] e;
          e = exp_q.pop_front();
          checks--;
          chk("in_fifo_at_en", in_fifo, e);
        end
        chk("en_one_cycle", prev_en, 1'b0);
      end
      if (frame_err) begin
        checks++;
        if (err_q.size() == 0) begin
          failures++;
          $display("FAIL frame_err_unexpected: frame_err=1 with none expected");
        end else begin
          void'(err_q.pop_front());
        end
        chk("frame_err_one_cycle", prev_err, 1'b0);
      end
    end
    prev_en  = en;
    prev_err = frame_err;
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the word
  // has transferred.
  task automatic drive_word(input logic [W-1:0] d, input logic last);
    int n;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL tready_timeout: tready=0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      drive_word(fr[i], (i == n - 1));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Produce a clean done rising edge and check the hand-back.
  task automatic complete();
    done = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_done", busy, 1'b1);
    done = 1'b1;
    @(negedge clk);
    chk("tready_after_done", s_axis_tready, 1'b1);
    chk("busy_after_done", busy, 1'b0);
    done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_en", en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_in_fifo", in_fifo, '0);
    chk("rst_state", state_dbg, 2'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("tready_after_rst", s_axis_tready, 1'b1);

    // Good frame with a stale done level already high
    for (int i = 0; i < N; i++) fr[i] = i;
    done = 1'b1;
    exp_q.push_back(pack_frame());
    send_frame(N, 1'b0);
    chk("s1_en_latency", en, 1'b1);
    chk("s1_busy_start", busy, 1'b1);
    chk("s1_tready_start", s_axis_tready, 1'b0);
    @(negedge clk);
    chk("s1_en_drop", en, 1'b0);
    chk("s1_busy_wait", busy, 1'b1);
    chk("s1_tready_wait", s_axis_tready, 1'b0);
    chk("s1_word19", in_fifo[19*W +: W], 32'h13);
    repeat (3) @(negedge clk);
    chk("s2_stale_done_ignored", busy, 1'b1);
    done = 1'b0;
    repeat (2) @(negedge clk);
    chk("s2_busy_done_low", busy, 1'b1);
    done = 1'b1;
    @(negedge clk);
    chk("s2_tready_after_edge", s_axis_tready, 1'b1);
    chk("s2_busy_after_edge", busy, 1'b0);
    done = 1'b0;

    // Short frame, then good frame of A5
    for (int i = 0; i < 6; i++) fr[i] = 32'h100 + i;
    err_q.push_back(1'b1);
    send_frame(6, 1'b0);
    chk("s3_frame_err", frame_err, 1'b1);
    chk("s3_no_en", en, 1'b0);
    chk("s3_tready", s_axis_tready, 1'b1);
    @(negedge clk);
    chk("s3_frame_err_drop", frame_err, 1'b0);
    for (int i = 0; i < N; i++) fr[i] = 32'hA5A5A5A5;
    exp_q.push_back(pack_frame());
    send_frame(N, 1'b0);
    chk("s3_en", en, 1'b1);
    complete();

    // Long frame: 25 words
    for (int i = 0; i < 25; i++) fr[i] = 32'h200 + i;
    err_q.push_back(1'b1);
    send_frame(25, 1'b0);
    chk("s4_frame_err", frame_err, 1'b1);
    chk("s4_no_en", en, 1'b0);
    chk("s4_busy", busy, 1'b0);
    chk("s4_in_fifo", in_fifo, pack_frame());

    // Gapped frame
    @(negedge clk);
    for (int i = 0; i < N; i++) fr[i] = 32'h300 + i;
    exp_q.push_back(pack_frame());
    send_frame(N, 1'b1);
    chk("s5_en_gaps", en, 1'b1);
    complete();

    // Reset in the middle of a frame
    for (int i = 0; i < 10; i++) drive_word(32'h400 + i, 1'b0);
    s_axis_tvalid = 1'b0;
    reset = 1'b0;
    #1;
    chk("s5_rst_in_fifo", in_fifo, '0);
    chk("s5_rst_tready", s_axis_tready, 1'b0);
    chk("s5_rst_busy", busy, 1'b0);
    chk("s5_rst_en", en, 1'b0);
    chk("s5_rst_frame_err", frame_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) fr[i] = 32'h500 + i;
    exp_q.push_back(pack_frame());
    send_frame(N, 1'b0);
    chk("s5_en_after_rst", en, 1'b1);
    complete();

    // Byte order of stored words
    fr[0] = 32'h11223344;
    for (int i = 1; i < N; i++) fr[i] = 32'h600 + i;
    exp_q.push_back(pack_frame());
    send_frame(N, 1'b0);
    chk("s6_en", en, 1'b1);
`ifdef LOADER_BYTE_SWAP_EN
    chk("s6_word0", in_fifo[W-1:0], 32'h44332211);
`else
    chk("s6_word0", in_fifo[W-1:0], 32'h11223344);
`endif
    complete();

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_miner_loader.md
Name: axis_miner_loader

Overview:
- Upstream stage of the AXI-Stream bitcoin miner wrapper.
- Accepts one block-header frame of NUMBER_OF_INPUT_WORDS words on an AXI-Stream slave and packs it into the flat in_fifo bus the miner consumes.
- Issues a one-cycle start pulse, then holds off further input until the miner reports done.
- Validates frame length against tlast and drops malformed frames.

Parameters:
- NUMBER_OF_INPUT_WORDS, 20: words per frame (header: version, prev hash x8, merkle x8, time, nbits, nonce).
- AXIS_TDATA_WIDTH, 32: stream word width in bits.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  last word of frame.
- s_axis_tready  out  1  stream ready.
- in_fifo  out  NUMBER_OF_INPUT_WORDS*AXIS_TDATA_WIDTH  packed frame; word j at bits [j*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH].
- en  out  1  one-cycle start pulse to the miner.
- done  in  1  miner completion; level, registered by the miner.
- busy  out  1  high from frame capture complete until miner completion.
- frame_err  out  1  one-cycle pulse per dropped malformed frame.

Behaviour:
- Reset (async assert, sync release): state RECV, word count 0, in_fifo all zero, en 0, busy 0, frame_err 0, s_axis_tready 0 during reset, done_q 0.
- Transfer occurs when s_axis_tvalid && s_axis_tready on a rising edge.
- States:
  - RECV: tready=1.
    - Each transfer writes tdata into word[count].
    - Normal word (count < N-1, tlast=0): count++.
    - Short frame (tlast=1 with count < N-1): frame_err pulses the next cycle; count returns to 0; stay in RECV.
    - Good frame (count == N-1, tlast=1): go to START; count returns to 0.
    - Long frame (count == N-1, tlast=0): go to DRAIN; count returns to 0.
  - DRAIN: tready=1; transfers are discarded and in_fifo is not written. On a transfer with tlast=1: frame_err pulses, go to RECV.
  - START: lasts exactly one cycle; tready=0; en=1; busy=1; go to WAIT.
  - WAIT: tready=0; busy=1. Completion is the rising edge of done (done && !done_q, with done_q registered every cycle). On completion: busy=0, go to RECV.
- Level-high done that is still stale from a previous job is ignored; only a 0->1 edge seen in WAIT completes.
- A done edge seen in any other state is ignored.
- Latency:
  - en is asserted 1 cycle after the final accepted word.
  - tready re-asserts 1 cycle after the done rising edge is sampled.
- in_fifo stability:
  - Contents are stable from START through WAIT.
  - Words are overwritten only by new transfers in RECV.
  - After a short frame, in_fifo holds partial data; this is harmless because en is not issued.
- tvalid may drop mid-frame; the count holds, with no timeout.
- N=1: the first word must carry tlast, otherwise DRAIN.
- Count width: clog2(N), minimum 1 bit. The count never exceeds N-1.
- Reset asserted mid-frame or mid-WAIT: immediate return to reset values. Any pending en or busy is cleared.

Optional Feature:
- LOADER_BYTE_SWAP_EN defined: each captured word is byte-reversed before storage (tdata[7:0] goes to bits [31:24], etc.), converting the little-endian serialized header to the miner's big-endian words. AXIS_TDATA_WIDTH must be a multiple of 8.
- Undefined: words are stored verbatim.

Test Plan:
1. Good frame: send 20 words 0x00000000..0x00000013, tlast on word 19, tvalid continuous -> in_fifo word j = j; en high exactly 1 cycle, 1 cycle after the last transfer; tready low and busy high afterward.
2. Completion: from scenario 1 hold done=1 already before en, then 0, then 1 -> no completion on the stale level; completion only on the 0->1 edge; tready=1 the next cycle.
3. Short frame: tlast on word 5 -> frame_err one pulse, no en; a following good frame of 0xA5A5A5A5 words produces en and in_fifo all 0xA5A5A5A5.
4. Long frame: 25 words with tlast on word 24 -> words 20-24 discarded, frame_err one pulse after word 24, no en; previous in_fifo words 0-19 reflect the first 20 words.
5. Backpressure gaps plus reset: tvalid toggling every other cycle during a frame -> correct packing. Assert reset at word 10 -> all outputs zero; the next full frame is captured from word 0.
6. With LOADER_BYTE_SWAP_EN: word 0x11223344 -> stored 0x44332211. Without the macro -> stored 0x11223344.
